// File: rtl/psum_accum_16b.sv
// Multi-pass signed psum accumulator with optional per-lane bias and saturating lanes.
// Optional feature: define PSUM_ACC_SAT_CNT_EN to add the o_sat_cnt lane-saturation counter.

module psum_accum_lane #(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] sum,
    output logic              sat
);
    logic [DATA_W:0] s;

    assign s   = {a[DATA_W-1], a} + {b[DATA_W-1], b};
    // Overflow iff the two top bits of the 17-bit sum disagree; the sign bit picks the rail.
    assign sat = s[DATA_W] ^ s[DATA_W-1];
    assign sum = !sat      ? s[DATA_W-1:0] :
                 s[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} :
                             {1'b0, {(DATA_W-1){1'b1}}};
endmodule

module psum_accum_16b #(
    parameter int LANES  = 8,
    parameter int DATA_W = 16,
    parameter int CNT_W  = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_clr,
    input  logic [CNT_W-1:0]        i_cfg_pass_num,
    input  logic                    i_bias_en,
    input  logic [LANES*DATA_W-1:0] i_bias,
    input  logic                    i_psum_vld,
    output logic                    o_psum_rdy,
    input  logic [LANES*DATA_W-1:0] i_psum_dat,
    output logic                    o_acc_vld,
    input  logic                    i_acc_rdy,
    output logic [LANES*DATA_W-1:0] o_acc_dat,
    output logic                    o_sat_flag,
    output logic                    o_busy
`ifdef PSUM_ACC_SAT_CNT_EN
    ,
    output logic [15:0]             o_sat_cnt
`endif
);
    typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;

    state_t                         state, state_nxt;
    logic [LANES-1:0][DATA_W-1:0]   acc, bias_v, psum_v, opnd, sum;
    logic [LANES-1:0]               lane_sat;
    logic [CNT_W-1:0]               pass_q, pass_eff, cnt;
    logic                           accept, first;

    assign bias_v     = i_bias;
    assign psum_v     = i_psum_dat;
    assign o_acc_dat  = acc;
    assign o_acc_vld  = (state == OUT);
    assign o_busy     = (state != IDLE);
    assign o_psum_rdy = (state == OUT) ? i_acc_rdy : 1'b1;

    // A beat taken in OUT implies the result is consumed the same cycle, so it starts a new group.
    assign accept   = i_psum_vld && o_psum_rdy && !i_clr;
    assign first    = accept && (state != ACCUM);
    assign pass_eff = (i_cfg_pass_num == '0) ? CNT_W'(1) : i_cfg_pass_num;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign opnd[k] = !first ? acc[k] : (i_bias_en ? bias_v[k] : '0);
        psum_accum_lane #(.DATA_W(DATA_W)) u_lane (
            .a   (opnd[k]),
            .b   (psum_v[k]),
            .sum (sum[k]),
            .sat (lane_sat[k])
        );
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (accept) state_nxt = (pass_eff == CNT_W'(1)) ? OUT : ACCUM;
            ACCUM: if (accept && (CNT_W'(cnt + 1'b1) == pass_q)) state_nxt = OUT;
            OUT: begin
                if (i_acc_rdy) begin
                    if (accept) state_nxt = (pass_eff == CNT_W'(1)) ? OUT : ACCUM;
                    else        state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (i_clr) state_nxt = IDLE;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            acc        <= '0;
            cnt        <= '0;
            pass_q     <= '0;
            o_sat_flag <= 1'b0;
        end else if (i_clr) begin
            state      <= IDLE;
            acc        <= '0;
            cnt        <= '0;
            pass_q     <= '0;
            o_sat_flag <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                acc <= sum;
                if (first) begin
                    pass_q     <= pass_eff;
                    cnt        <= CNT_W'(1);
                    o_sat_flag <= |lane_sat;
                end else begin
                    cnt        <= CNT_W'(cnt + 1'b1);
                    o_sat_flag <= o_sat_flag | (|lane_sat);
                end
            end
        end
    end

`ifdef PSUM_ACC_SAT_CNT_EN
    logic [16:0] sat_sum;

    always_comb begin
        sat_sum = {1'b0, o_sat_cnt};
        for (int k = 0; k < LANES; k++) sat_sum = sat_sum + 17'(lane_sat[k]);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)    o_sat_cnt <= '0;
        else if (i_clr)  o_sat_cnt <= '0;
        else if (accept) o_sat_cnt <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
    end
`endif
endmodule

// File: tb/tb_psum_accum_16b.sv
// Bench for psum_accum_16b: vector table, corner-case sequences, randomized run vs. integer model.
module tb_psum_accum_16b;
    localparam int LANES = 8;
    localparam int W     = LANES * 16;
    localparam int NG    = 40;

    logic         i_clk = 0, i_rst_n = 0, i_clr = 0, i_bias_en = 0;
    logic [7:0]   i_cfg_pass_num = 0;
    logic [W-1:0] i_bias = '0, i_psum_dat = '0;
    logic         i_psum_vld = 0, i_acc_rdy = 1;
    logic         o_psum_rdy, o_acc_vld, o_sat_flag, o_busy;
    logic [W-1:0] o_acc_dat;
`ifdef PSUM_ACC_SAT_CNT_EN
    logic [15:0]  o_sat_cnt;
    int           m_satcnt;
`endif

    psum_accum_16b dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clr(i_clr),
        .i_cfg_pass_num(i_cfg_pass_num), .i_bias_en(i_bias_en), .i_bias(i_bias),
        .i_psum_vld(i_psum_vld), .o_psum_rdy(o_psum_rdy), .i_psum_dat(i_psum_dat),
        .o_acc_vld(o_acc_vld), .i_acc_rdy(i_acc_rdy), .o_acc_dat(o_acc_dat),
        .o_sat_flag(o_sat_flag), .o_busy(o_busy)
`ifdef PSUM_ACC_SAT_CNT_EN
        , .o_sat_cnt(o_sat_cnt)
`endif
    );

    always #5 i_clk = ~i_clk;

    int checks = 0, errors = 0;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic int clamp(input int s, output bit c);
        c = 1'b0;
        if (s > 32767)  begin c = 1'b1; return 32767;  end
        if (s < -32768) begin c = 1'b1; return -32768; end
        return s;
    endfunction

    typedef struct {
        int          np;
        bit          ben;
        logic [15:0] bias, p0, p1, exp;
        bit          esat;
    } vec_t;
    vec_t tbl[10];

    typedef struct {
        logic [W-1:0] dat;
        bit           sat;
    } res_t;
    res_t expq[$];

    logic [W-1:0] gp[NG][4];
    logic [W-1:0] gb[NG];
    bit           gen[NG];
    int           gpn[NG];

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        i_acc_rdy = 1;
        for (int b = 0; b < v.np; b++) begin
            if (b == 0) begin
                i_cfg_pass_num = 8'(v.np);
                i_bias_en      = v.ben;
                i_bias         = {LANES{v.bias}};
            end else begin
                i_cfg_pass_num = 8'd1;
                i_bias_en      = ~v.ben;
                i_bias         = {LANES{16'h1111}};
            end
            i_psum_dat = {LANES{(b == 0) ? v.p0 : v.p1}};
            i_psum_vld = 1;
            tick();
        end
        i_psum_vld = 0;
        chk($sformatf("tbl%0d_vld", idx), W'(o_acc_vld), W'(1));
        chk($sformatf("tbl%0d_dat", idx), o_acc_dat, {LANES{v.exp}});
        chk($sformatf("tbl%0d_sat", idx), W'(o_sat_flag), W'(v.esat));
        tick();
        chk($sformatf("tbl%0d_idle", idx), W'({o_acc_vld, o_busy}), W'(0));
    endtask

    initial begin
        logic [W-1:0] held;
        int k;
        bit c;
        bit done;
        int gi, bi, nb, p, s, macc[LANES];
        bit msat;
        res_t e;

        tbl[0] = '{1, 0, 16'h0000, 16'h0123, 16'h0000, 16'h0123, 0};
        tbl[1] = '{2, 1, 16'd100,  16'd10,   16'd20,   16'd130,  0};
        tbl[2] = '{2, 0, 16'h0000, 16'h7000, 16'h2000, 16'h7FFF, 1};
        tbl[3] = '{2, 0, 16'h0000, 16'h9000, 16'hA000, 16'h8000, 1};
        tbl[4] = '{1, 1, 16'h7FFF, 16'h0001, 16'h0000, 16'h7FFF, 1};
        tbl[5] = '{1, 1, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1};
        tbl[6] = '{2, 0, 16'h0000, 16'h7FFF, 16'h8000, 16'hFFFF, 0};
        tbl[7] = '{1, 0, 16'h1000, 16'h0005, 16'h0000, 16'h0005, 0};
        tbl[8] = '{2, 0, 16'h0000, 16'h7000, 16'h9000, 16'h0000, 0};
        tbl[9] = '{2, 1, 16'h7FFF, 16'h0010, 16'h8000, 16'hFFFF, 1};

        #12 i_rst_n = 1;
        tick();
        chk("rst_vld", W'(o_acc_vld), W'(0));
        chk("rst_dat", o_acc_dat, '0);
        chk("rst_sat_busy", W'({o_sat_flag, o_busy}), W'(0));
        chk("rst_rdy", W'(o_psum_rdy), W'(1));

        for (int i = 0; i < 10; i++) run_vec(tbl[i], i);

        // Stall: result must hold while downstream is not ready, and beats are refused.
        i_cfg_pass_num = 1; i_bias_en = 0; i_acc_rdy = 0;
        i_psum_dat = {LANES{16'h0123}}; i_psum_vld = 1;
        tick();
        i_psum_dat = {LANES{16'h0777}};
        for (int i = 0; i < 3; i++) begin
            chk("stall_rdy", W'({o_acc_vld, o_psum_rdy}), W'(2'b10));
            chk("stall_dat", o_acc_dat, {LANES{16'h0123}});
            tick();
        end
        i_psum_vld = 0; i_acc_rdy = 1;
        tick();
        chk("stall_drain", W'(o_acc_vld), W'(0));

        // Back-to-back single-pass groups with pass_num=0.
        i_cfg_pass_num = 0;
        for (int i = 0; i < 8; i++) begin
            i_psum_dat = {LANES{16'(i * 3 + 1)}}; i_psum_vld = 1;
            tick();
            chk("tput_vld", W'(o_acc_vld), W'(1));
            chk("tput_dat", o_acc_dat, {LANES{16'(i * 3 + 1)}});
        end
        i_psum_vld = 0;
        tick();
        chk("tput_end", W'(o_acc_vld), W'(0));

        // Clear mid-group drops the group and the beat presented with it.
        i_cfg_pass_num = 4; i_psum_dat = {LANES{16'd7}}; i_psum_vld = 1;
        tick(); tick();
        i_clr = 1; i_psum_dat = {LANES{16'd100}};
        tick();
        i_clr = 0; i_psum_vld = 0;
        chk("clr_state", W'({o_acc_vld, o_busy, o_sat_flag}), W'(0));
        chk("clr_dat", o_acc_dat, '0);
        tick();
        chk("clr_novld", W'(o_acc_vld), W'(0));
        i_cfg_pass_num = 1; i_psum_dat = {LANES{16'd5}}; i_psum_vld = 1;
        tick();
        i_psum_vld = 0;
        chk("clr_next", o_acc_dat, {LANES{16'd5}});
        tick();

        // Asynchronous reset while holding a result.
        i_acc_rdy = 0; i_psum_dat = {LANES{16'h0123}}; i_psum_vld = 1;
        tick();
        i_psum_vld = 0;
        chk("arst_pre", W'(o_acc_vld), W'(1));
        #2 i_rst_n = 0;
        #1;
        chk("arst_vld", W'({o_acc_vld, o_busy}), W'(0));
        chk("arst_dat", o_acc_dat, '0);
        @(negedge i_clk); i_rst_n = 1; i_acc_rdy = 1;
        tick();

`ifdef PSUM_ACC_SAT_CNT_EN
        i_bias_en = 1; i_bias = '0; i_bias[15:0] = 16'h7FFF; i_bias[31:16] = 16'h7FFF;
        i_psum_dat = {LANES{16'd1}}; i_psum_vld = 1;
        tick();
        i_psum_vld = 0; i_bias_en = 0;
        chk("satcnt_two", W'(o_sat_cnt), W'(2));
        tick();
`endif

        // Randomized groups against an integer model.
        for (int g = 0; g < NG; g++) begin
            gpn[g] = $urandom_range(0, 4);
            gen[g] = $urandom_range(0, 1);
            for (int l = 0; l < LANES; l++) gb[g][l*16 +: 16] = 16'($urandom);
            for (int b = 0; b < 4; b++)
                for (int l = 0; l < LANES; l++) gp[g][b][l*16 +: 16] = 16'($urandom);
        end
        i_clr = 1;
        tick();
        i_clr = 0;
`ifdef PSUM_ACC_SAT_CNT_EN
        m_satcnt = 0;
`endif
        gi = 0; bi = 0; msat = 0; done = 0;
        for (int cyc = 0; cyc < 5000 && !done; cyc++) begin
            if (gi < NG) begin
                i_psum_vld = ($urandom % 4) != 0;
                i_psum_dat = gp[gi][bi];
                if (bi == 0) begin
                    i_cfg_pass_num = 8'(gpn[gi]); i_bias_en = gen[gi]; i_bias = gb[gi];
                end else begin
                    i_cfg_pass_num = 8'($urandom); i_bias_en = $urandom_range(0, 1);
                    i_bias = {LANES{16'($urandom)}};
                end
            end else i_psum_vld = 0;
            i_acc_rdy = ($urandom % 3) != 0;
            #1;
            if (o_acc_vld && i_acc_rdy) begin
                if (expq.size() == 0) chk("rand_spurious", W'(1), W'(0));
                else begin
                    e = expq.pop_front();
                    chk("rand_dat", o_acc_dat, e.dat);
                    chk("rand_sat", W'(o_sat_flag), W'(e.sat));
                end
            end
            if (i_psum_vld && o_psum_rdy) begin
                nb = (gpn[gi] == 0) ? 1 : gpn[gi];
                if (bi == 0) msat = 0;
                for (k = 0; k < LANES; k++) begin
                    p = int'($signed(gp[gi][bi][k*16 +: 16]));
                    if (bi == 0) s = p + (gen[gi] ? int'($signed(gb[gi][k*16 +: 16])) : 0);
                    else         s = macc[k] + p;
                    macc[k] = clamp(s, c);
                    msat |= c;
`ifdef PSUM_ACC_SAT_CNT_EN
                    m_satcnt += int'(c);
`endif
                end
                bi++;
                if (bi == nb) begin
                    for (k = 0; k < LANES; k++) e.dat[k*16 +: 16] = 16'(macc[k]);
                    e.sat = msat;
                    expq.push_back(e);
                    gi++; bi = 0;
                end
            end
            @(posedge i_clk);
            #1;
            done = (gi == NG) && (expq.size() == 0);
        end
        chk("rand_done", W'(done), W'(1));
`ifdef PSUM_ACC_SAT_CNT_EN
        chk("rand_satcnt", W'(o_sat_cnt), W'(m_satcnt > 65535 ? 65535 : m_satcnt));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
